serial_io_buffer: RTL and testbench
===================================

// Module: serial_io_buffer
// PURPOSE
//   Buffers the processor's serial port so that CPU stalls and external link stalls do not stall each other.
//   It sits directly downstream of the processor's serial_* ports, which come out of the data_memory
//   serial path, and upstream of the external byte link (UART/host bridge).
//   Two independent byte FIFOs: TX (processor -> link) and RX (link -> processor). Both are first-word-fall-through.
// PARAMETERS
//   DEPTH_LOG2  4  log2 of the entry count of each FIFO (default 16 entries). Counts are DEPTH_LOG2+1 bits wide.
// PORTS
//   clock            in   1  single clock; all state updates on posedge
//   reset            in   1  asynchronous, active-low; 0 clears all state immediately
//   proc_wdata_in    in   8  TX byte from the processor (serial_out)
//   proc_wren_in     in   1  TX push request (serial_wren_out)
//   proc_rden_in     in   1  RX pop request (serial_rden_out)
//   proc_rdata_out   out  8  RX head byte to the processor (serial_in)
//   proc_valid_out   out  1  RX FIFO non-empty (serial_valid_in)
//   proc_ready_out   out  1  TX FIFO not full (serial_ready_in)
//   ext_tx_data_out  out  8  TX head byte to the link
//   ext_tx_valid_out out  1  TX FIFO non-empty
//   ext_tx_ready_in  in   1  link accepts a TX byte
//   ext_rx_data_in   in   8  byte from the link
//   ext_rx_valid_in  in   1  link offers an RX byte
//   ext_rx_ready_out out  1  RX FIFO not full
//   tx_drop_out      out  1  sticky: a push was attempted while TX was full
//   rx_drop_out      out  1  sticky: ext_rx_valid_in was high while RX was full
// BEHAVIOUR
//   Reset values: pointers = 0 and counts = 0; proc_valid_out = 0, ext_tx_valid_out = 0.
//     proc_ready_out = 1 and ext_rx_ready_out = 1. Data outputs = 8'h00. Drop flags = 0. FIFO contents are don't-care.
//   Reset asserted mid-operation clears every FIFO immediately; in-flight bytes are lost.
//   Full, empty, ready and valid are all decoded from the registered counts.
//   Push/pop rules:
//     TX push: proc_wren_in && proc_ready_out at posedge.
//     TX pop:  ext_tx_valid_out && ext_tx_ready_in.
//     RX push: ext_rx_valid_in && ext_rx_ready_out.
//     RX pop:  proc_rden_in && proc_valid_out.
//   Latency: a byte pushed at edge N is at the head, with valid high, after edge N.
//     The head is visible combinationally from the storage array.
//   Rejected requests:
//     Push into a full FIFO is dropped, and its drop flag is set (sticky until reset).
//     Full is judged before any same-cycle pop, so a push is rejected even if a pop occurs in the same cycle.
//     Pop from an empty FIFO is ignored, with no state change and no flag.
//   Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged, both pointers advance.
//   Pointers are DEPTH_LOG2 bits and wrap modulo 2**DEPTH_LOG2. Ordering is strictly FIFO.
//   Data outputs are masked to 8'h00 while the corresponding valid is 0.
//   Throughput: 1 byte per cycle per direction; the two directions are fully independent.
// CONFIGURATION
//   SERIAL_LOOPBACK_EN defined:
//     Adds input port loopback_in (1 bit), placed after ext_rx_ready_out.
//     When loopback_in = 1:
//       Each cycle, the TX head moves into the RX tail if TX is non-empty and RX is not full (1 byte/cycle).
//       ext_tx_valid_out is forced to 0 and ext_rx_ready_out is forced to 0.
//       The external ports are ignored.
//       A loopback transfer is never counted as a drop.
//   SERIAL_LOOPBACK_EN undefined: the loopback_in port and its logic are absent; behaviour is as above.
// TESTING
//   T1 Reset: apply reset = 0 mid-cycle.
//      -> Immediately proc_valid_out = 0, ext_tx_valid_out = 0, proc_ready_out = 1, ext_rx_ready_out = 1, drops = 0.
//   T2 TX order: push 0x41 then 0x42 with ext_tx_ready_in = 0.
//      -> ext_tx_data_out = 0x41, valid = 1.
//      -> Raise ready: 0x41 then 0x42 on consecutive edges, then valid = 0.
//   T3 TX full: push 16 bytes 0x00..0x0F with the link stalled; 17th push is 0xFF.
//      -> proc_ready_out = 0 and tx_drop_out = 1.
//      -> Drain yields 0x00..0x0F only.
//   T4 RX: link sends 0x55, 0xAA.
//      -> proc_valid_out = 1 and proc_rdata_out = 0x55 one edge after the first transfer.
//      -> rden shows 0xAA; second rden empties the FIFO; a further rden on empty causes no change.
//   T5 Wrap and concurrency: stream 40 bytes 0x00..0x27 with push and pop in the same cycle at count 1.
//      -> Count stays 1, output order is exact, and the pointers wrap twice.
//   T6 (SERIAL_LOOPBACK_EN) loopback_in = 1, push 0x5A.
//      -> proc_valid_out = 1 with 0x5A.
//      -> ext_tx_valid_out = 0 throughout and ext_rx_ready_out = 0.

Source files
------------

// File: rtl/serial_io_buffer.sv
// Two independent first-word-fall-through byte FIFOs between the CPU serial port and the byte link.
// Define SERIAL_LOOPBACK_EN to add loopback_in, which routes the TX FIFO into the RX FIFO.

module serial_io_buffer_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push_in,
  input  logic [7:0] push_data_in,
  input  logic       pop_in,
  output logic [7:0] head_out,
  output logic       empty_out,
  output logic       full_out
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT =
    (DEPTH_LOG2+1)'(DEPTH);

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  push_ok, pop_ok;

  // Flags come from the registered count only.
  assign empty_out = (count_q == '0);
  assign full_out  = (count_q == FULL_CNT);

  // Full/empty are judged before any same-cycle pop or push.
  assign push_ok = push_in && !full_out;
  assign pop_ok  = pop_in && !empty_out;

  // Head is read straight out of storage.
  assign head_out = mem_q[rptr_q];

  // Next-state for pointers and occupancy.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop_ok)  rptr_d = rptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; contents are only seen when count is non-zero.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wptr_q] <= push_data_in;
  end

endmodule

module serial_io_buffer #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] proc_wdata_in,
  input  logic       proc_wren_in,
  input  logic       proc_rden_in,
  output logic [7:0] proc_rdata_out,
  output logic       proc_valid_out,
  output logic       proc_ready_out,
  output logic [7:0] ext_tx_data_out,
  output logic       ext_tx_valid_out,
  input  logic       ext_tx_ready_in,
  input  logic [7:0] ext_rx_data_in,
  input  logic       ext_rx_valid_in,
  output logic       ext_rx_ready_out,
`ifdef SERIAL_LOOPBACK_EN
  input  logic       loopback_in,
`endif
  output logic       tx_drop_out,
  output logic       rx_drop_out
);

  logic       lb;
  logic       tx_push, tx_pop, tx_empty, tx_full;
  logic       rx_push, rx_pop, rx_empty, rx_full;
  logic [7:0] tx_head, rx_head, rx_wdata;
  logic       tx_drop_q, tx_drop_d;
  logic       rx_drop_q, rx_drop_d;

`ifdef SERIAL_LOOPBACK_EN
  assign lb = loopback_in;
`else
  assign lb = 1'b0;
`endif

  serial_io_buffer_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx (
    .clock       (clock),
    .reset       (reset),
    .push_in     (tx_push),
    .push_data_in(proc_wdata_in),
    .pop_in      (tx_pop),
    .head_out    (tx_head),
    .empty_out   (tx_empty),
    .full_out    (tx_full)
  );

  serial_io_buffer_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx (
    .clock       (clock),
    .reset       (reset),
    .push_in     (rx_push),
    .push_data_in(rx_wdata),
    .pop_in      (rx_pop),
    .head_out    (rx_head),
    .empty_out   (rx_empty),
    .full_out    (rx_full)
  );

  // Route FIFO requests; loopback feeds the TX head into the RX tail.
  always_comb begin
    tx_push  = proc_wren_in;
    rx_pop   = proc_rden_in;
    tx_pop   = ext_tx_ready_in;
    rx_push  = ext_rx_valid_in;
    rx_wdata = ext_rx_data_in;
    if (lb) begin
      tx_pop   = !tx_empty && !rx_full;
      rx_push  = tx_pop;
      rx_wdata = tx_head;
    end
  end

  assign proc_ready_out   = !tx_full;
  assign proc_valid_out   = !rx_empty;
  assign ext_tx_valid_out = !tx_empty && !lb;
  assign ext_rx_ready_out = !rx_full && !lb;

  // Data is zero whenever its valid is low.
  assign ext_tx_data_out = ext_tx_valid_out ? tx_head : 8'h00;
  assign proc_rdata_out  = proc_valid_out ? rx_head : 8'h00;

  // A loopback move is gated by RX space, so it never counts as a drop.
  always_comb begin
    tx_drop_d = tx_drop_q | (proc_wren_in & tx_full);
    rx_drop_d = rx_drop_q | (ext_rx_valid_in & rx_full & !lb);
  end

  // Sticky drop flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_drop_q <= 1'b0;
      rx_drop_q <= 1'b0;
    end else begin
      tx_drop_q <= tx_drop_d;
      rx_drop_q <= rx_drop_d;
    end
  end

  assign tx_drop_out = tx_drop_q;
  assign rx_drop_out = rx_drop_q;

endmodule

// File: tb/tb_serial_io_buffer.sv
// Scoreboard bench for serial_io_buffer.
// Stimulus queues expected bytes; a negedge monitor checks every transfer.

module tb_serial_io_buffer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] proc_wdata_in = '0;
  logic       proc_wren_in = 1'b0;
  logic       proc_rden_in = 1'b0;
  logic [7:0] proc_rdata_out;
  logic       proc_valid_out;
  logic       proc_ready_out;
  logic [7:0] ext_tx_data_out;
  logic       ext_tx_valid_out;
  logic       ext_tx_ready_in = 1'b0;
  logic [7:0] ext_rx_data_in = '0;
  logic       ext_rx_valid_in = 1'b0;
  logic       ext_rx_ready_out;
`ifdef SERIAL_LOOPBACK_EN
  logic       loopback_in = 1'b0;
`endif
  logic       tx_drop_out;
  logic       rx_drop_out;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];

  always #5 clock = ~clock;

  serial_io_buffer dut (
    .clock           (clock),
    .reset           (reset),
    .proc_wdata_in   (proc_wdata_in),
    .proc_wren_in    (proc_wren_in),
    .proc_rden_in    (proc_rden_in),
    .proc_rdata_out  (proc_rdata_out),
    .proc_valid_out  (proc_valid_out),
    .proc_ready_out  (proc_ready_out),
    .ext_tx_data_out (ext_tx_data_out),
    .ext_tx_valid_out(ext_tx_valid_out),
    .ext_tx_ready_in (ext_tx_ready_in),
    .ext_rx_data_in  (ext_rx_data_in),
    .ext_rx_valid_in (ext_rx_valid_in),
    .ext_rx_ready_out(ext_rx_ready_out),
`ifdef SERIAL_LOOPBACK_EN
    .loopback_in     (loopback_in),
`endif
    .tx_drop_out     (tx_drop_out),
    .rx_drop_out     (rx_drop_out)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name,
                       input logic [7:0] act,
                       input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h",
               name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " proc_valid"}, {7'd0, proc_valid_out}, 8'd0);
    check({tag, " tx_valid"}, {7'd0, ext_tx_valid_out}, 8'd0);
    check({tag, " proc_ready"}, {7'd0, proc_ready_out}, 8'd1);
    check({tag, " rx_ready"}, {7'd0, ext_rx_ready_out}, 8'd1);
    check({tag, " tx_drop"}, {7'd0, tx_drop_out}, 8'd0);
    check({tag, " rx_drop"}, {7'd0, rx_drop_out}, 8'd0);
    check({tag, " tx_data"}, ext_tx_data_out, 8'h00);
    check({tag, " rx_data"}, proc_rdata_out, 8'h00);
  endtask

  // Transfers happen at the next posedge when valid && ready here.
  always @(negedge clock) begin
    if (reset) begin
      if (ext_tx_valid_out && ext_tx_ready_in) begin
        vectors++;
        if (tx_q.size() == 0) begin
          miscompares++;
          $display("FAIL tx_extra: got %02h expected none",
                   ext_tx_data_out);
        end else begin
          logic [7:0] e;
          e = tx_q.pop_front();
          if (ext_tx_data_out !== e) begin
            miscompares++;
            $display("FAIL tx_data: got %02h expected %02h",
                     ext_tx_data_out, e);
          end
        end
      end
      if (proc_valid_out && proc_rden_in) begin
        vectors++;
        if (rx_q.size() == 0) begin
          miscompares++;
          $display("FAIL rx_extra: got %02h expected none",
                   proc_rdata_out);
        end else begin
          logic [7:0] e;
          e = rx_q.pop_front();
          if (proc_rdata_out !== e) begin
            miscompares++;
            $display("FAIL rx_data: got %02h expected %02h",
                     proc_rdata_out, e);
          end
        end
      end
    end
  end

  initial begin
    // T1: reset state
    #12;
    check_reset_state("T1");
    reset = 1'b1;
    step();

    // T2: TX order with link stalled, then drain
    proc_wren_in = 1'b1;
    proc_wdata_in = 8'h41; tx_q.push_back(8'h41);
    step();
    proc_wdata_in = 8'h42; tx_q.push_back(8'h42);
    step();
    proc_wren_in = 1'b0;
    check("T2 tx_valid", {7'd0, ext_tx_valid_out}, 8'd1);
    check("T2 tx_head", ext_tx_data_out, 8'h41);
    ext_tx_ready_in = 1'b1;
    step();
    step();
    check("T2 tx_empty", {7'd0, ext_tx_valid_out}, 8'd0);
    check("T2 tx_mask", ext_tx_data_out, 8'h00);
    ext_tx_ready_in = 1'b0;

    // T3: fill TX, reject 17th even with a same-cycle pop
    for (int i = 0; i < 16; i++) begin
      proc_wren_in = 1'b1;
      proc_wdata_in = 8'(i);
      tx_q.push_back(8'(i));
      step();
    end
    check("T3 ready_full", {7'd0, proc_ready_out}, 8'd0);
    check("T3 drop_pre", {7'd0, tx_drop_out}, 8'd0);
    proc_wdata_in = 8'hFF;
    ext_tx_ready_in = 1'b1;
    step();
    proc_wren_in = 1'b0;
    check("T3 drop_set", {7'd0, tx_drop_out}, 8'd1);
    check("T3 ready_back", {7'd0, proc_ready_out}, 8'd1);
    for (int i = 0; i < 16; i++) step();
    check("T3 drained", {7'd0, ext_tx_valid_out}, 8'd0);
    check("T3 drop_sticky", {7'd0, tx_drop_out}, 8'd1);
    ext_tx_ready_in = 1'b0;

    // T4: RX path
    ext_rx_valid_in = 1'b1;
    ext_rx_data_in = 8'h55; rx_q.push_back(8'h55);
    step();
    check("T4 rx_valid", {7'd0, proc_valid_out}, 8'd1);
    check("T4 rx_head", proc_rdata_out, 8'h55);
    ext_rx_data_in = 8'hAA; rx_q.push_back(8'hAA);
    step();
    ext_rx_valid_in = 1'b0;
    proc_rden_in = 1'b1;
    step();
    check("T4 rx_second", proc_rdata_out, 8'hAA);
    step();
    check("T4 rx_empty", {7'd0, proc_valid_out}, 8'd0);
    step();
    proc_rden_in = 1'b0;
    check("T4 rx_still_empty", {7'd0, proc_valid_out}, 8'd0);
    check("T4 rx_mask", proc_rdata_out, 8'h00);
    check("T4 rx_ready", {7'd0, ext_rx_ready_out}, 8'd1);
    check("T4 rx_nodrop", {7'd0, rx_drop_out}, 8'd0);

    // T4b: RX full, overflow sets rx_drop
    ext_rx_valid_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ext_rx_data_in = 8'h80 + 8'(i);
      rx_q.push_back(8'h80 + 8'(i));
      step();
    end
    check("T4b rx_full", {7'd0, ext_rx_ready_out}, 8'd0);
    ext_rx_data_in = 8'hEE;
    step();
    ext_rx_valid_in = 1'b0;
    check("T4b rx_drop", {7'd0, rx_drop_out}, 8'd1);
    proc_rden_in = 1'b1;
    for (int i = 0; i < 16; i++) step();
    proc_rden_in = 1'b0;
    check("T4b rx_drained", {7'd0, proc_valid_out}, 8'd0);

    // T5: stream 40 bytes with push and pop together at count 1
    proc_wren_in = 1'b1;
    proc_wdata_in = 8'h00; tx_q.push_back(8'h00);
    step();
    ext_tx_ready_in = 1'b1;
    for (int i = 1; i < 40; i++) begin
      proc_wdata_in = 8'(i);
      tx_q.push_back(8'(i));
      step();
      check("T5 count_one", {7'd0, ext_tx_valid_out}, 8'd1);
    end
    proc_wren_in = 1'b0;
    step();
    ext_tx_ready_in = 1'b0;
    check("T5 drained", {7'd0, ext_tx_valid_out}, 8'd0);

`ifdef SERIAL_LOOPBACK_EN
    // T6: loopback
    loopback_in = 1'b1;
    ext_tx_ready_in = 1'b1;
    proc_wren_in = 1'b1;
    proc_wdata_in = 8'h5A; rx_q.push_back(8'h5A);
    step();
    proc_wren_in = 1'b0;
    check("T6 tx_valid0", {7'd0, ext_tx_valid_out}, 8'd0);
    check("T6 rx_ready0", {7'd0, ext_rx_ready_out}, 8'd0);
    step();
    check("T6 tx_valid1", {7'd0, ext_tx_valid_out}, 8'd0);
    check("T6 lb_valid", {7'd0, proc_valid_out}, 8'd1);
    check("T6 lb_data", proc_rdata_out, 8'h5A);
    proc_rden_in = 1'b1;
    step();
    proc_rden_in = 1'b0;
    ext_tx_ready_in = 1'b0;
    loopback_in = 1'b0;
`endif

    check("queues_empty", 8'(tx_q.size() + rx_q.size()), 8'd0);

    // T1b: reset mid-operation drops in-flight bytes and flags
    proc_wren_in = 1'b1;
    proc_wdata_in = 8'h77;
    ext_rx_valid_in = 1'b1;
    ext_rx_data_in = 8'h66;
    step();
    proc_wren_in = 1'b0;
    ext_rx_valid_in = 1'b0;
    check("T1b tx_loaded", {7'd0, ext_tx_valid_out}, 8'd1);
    check("T1b rx_loaded", {7'd0, proc_valid_out}, 8'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("T1b");
    step();
    reset = 1'b1;
    step();
    check("T1b after_release", {7'd0, ext_tx_valid_out}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
